// File: rtl/jls_pkg.sv
// Shared definitions for the JPEG-LS frame sequencer.
//   state_t          : frame sequencer states
//   DEF_MAXLEN_LEVEL : default log2 bound on frame width
//   DEF_MIN_WIDTH    : default minimum legal frame width
//   BYTE_CNT_W       : width of the emitted-byte counter
package jls_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  localparam int unsigned DEF_MAXLEN_LEVEL = 12;
  localparam int unsigned DEF_MIN_WIDTH    = 4;
  localparam int unsigned BYTE_CNT_W       = 32;

endpackage

// File: rtl/jls_idle_timer.sv
// Inactivity timer used to decide when the encoder output has drained.
//   clk, rst  : clock, asynchronous active-high reset
//   en        : timer runs only while high; cleared otherwise
//   activity  : any activity restarts the count
//   expired   : high in the cycle that completes IDLE_CYCLES consecutive
//               enabled cycles without activity
module jls_idle_timer #(
  parameter int unsigned IDLE_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic activity,
  output logic expired
);

  localparam int unsigned CW = $clog2(IDLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(IDLE_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!en || activity) begin
      cnt_q <= '0;
    end else if (cnt_q != LAST) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // cnt_q holds the idle cycles already seen; the current idle cycle is the last one.
  assign expired = en && !activity && (cnt_q == LAST);

endmodule

// File: rtl/jls_frame_ctrl.sv
// Frame-level sequencer in front of jls_encoder. Accepts one frame
// descriptor, holds the encoder in reset for a setup window, streams
// width*height pixels, then waits for the encoder output to go quiet and
// reports completion with the emitted byte count.
//   cfg_valid/cfg_ready/cfg_width/cfg_height : frame descriptor handshake
//   cfg_err                                  : pulse, descriptor rejected
//   s_valid/s_ready/s_data                   : upstream pixel stream
//   enc_rst/enc_width/enc_height             : encoder frame control
//   enc_ivalid/enc_idata                     : encoder pixel input
//   enc_ovalid                               : encoder output byte strobe
//   done/done_bytes                          : frame complete, byte count
//   busy                                     : frame in progress
module jls_frame_ctrl
  import jls_pkg::*;
#(
  parameter int unsigned MAXLEN_LEVEL = DEF_MAXLEN_LEVEL,
  parameter int unsigned MIN_WIDTH    = DEF_MIN_WIDTH,
  parameter int unsigned SETUP_CYCLES = 16,
  parameter int unsigned DRAIN_IDLE   = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [MAXLEN_LEVEL-1:0] cfg_width,
  input  logic [15:0]             cfg_height,
  output logic                    cfg_err,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [7:0]              s_data,
  output logic                    enc_rst,
  output logic [MAXLEN_LEVEL-1:0] enc_width,
  output logic [15:0]             enc_height,
  output logic                    enc_ivalid,
  output logic [7:0]              enc_idata,
  input  logic                    enc_ovalid,
  output logic                    done,
  output logic [31:0]             done_bytes,
  output logic                    busy
);

  localparam int unsigned PIX_W = MAXLEN_LEVEL + 16;
  localparam int unsigned SET_W = $clog2(SETUP_CYCLES + 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETUP_CYCLES - 1);

  state_t                state_q, state_d;
  logic [SET_W-1:0]      setup_cnt_q;
  logic [PIX_W-1:0]      total_q;
  logic [PIX_W-1:0]      pixel_cnt_q;
  logic [BYTE_CNT_W-1:0] byte_cnt_q;
  logic                  accept, cfg_ok, xfer, last_pix, in_drain, drain_expired;

  assign accept   = cfg_valid && (state_q == IDLE);
  assign cfg_ok   = (cfg_width >= MAXLEN_LEVEL'(MIN_WIDTH)) && (cfg_height != '0);
  assign xfer     = s_valid && (state_q == STREAM);
  assign last_pix = xfer && (pixel_cnt_q == total_q - PIX_W'(1));
  assign in_drain = (state_q == DRAIN);

  jls_idle_timer #(.IDLE_CYCLES(DRAIN_IDLE)) u_idle (
    .clk     (clk),
    .rst     (rst),
    .en      (in_drain),
    .activity(enc_ovalid),
    .expired (drain_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cfg_ready = 1'b0;
    s_ready   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        cfg_ready = 1'b1;
        busy      = 1'b0;
        if (accept && cfg_ok) state_d = SETUP;
      end
      SETUP:   if (setup_cnt_q == SET_LAST) state_d = STREAM;
      STREAM: begin
        // s_ready follows the state, so it is gone the cycle after the last accept.
        s_ready = 1'b1;
        if (last_pix) state_d = DRAIN;
      end
      DRAIN:   if (drain_expired) state_d = DONE;
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Setup window counter and frame geometry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      setup_cnt_q <= '0;
      enc_width   <= '0;
      enc_height  <= '0;
      total_q     <= '0;
      pixel_cnt_q <= '0;
    end else begin
      if (state_q == SETUP) setup_cnt_q <= setup_cnt_q + SET_W'(1);
      else                  setup_cnt_q <= '0;
      if (accept && cfg_ok) begin
        enc_width   <= cfg_width;
        enc_height  <= cfg_height;
        pixel_cnt_q <= '0;
      end else if (xfer) begin
        pixel_cnt_q <= pixel_cnt_q + PIX_W'(1);
      end
      if (state_q == SETUP) total_q <= PIX_W'(enc_width) * PIX_W'(enc_height);
    end
  end

  // Pixel path. enc_rst drops with the first presented pixel and stays low
  // through stalls; it rises again the cycle after the last pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_rst    <= 1'b1;
      enc_ivalid <= 1'b0;
      enc_idata  <= '0;
    end else begin
      enc_ivalid <= xfer;
      if (xfer) enc_idata <= s_data;
      if (state_q == STREAM) begin
        if (xfer) enc_rst <= 1'b0;
      end else begin
        enc_rst <= 1'b1;
      end
    end
  end

  // Byte accounting and status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_q <= '0;
      done_bytes <= '0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_err <= accept && !cfg_ok;
      if (accept && cfg_ok) begin
        byte_cnt_q <= '0;
      end else if ((state_q != IDLE) && enc_ovalid && (byte_cnt_q != '1)) begin
        byte_cnt_q <= byte_cnt_q + BYTE_CNT_W'(1);
      end
      // The expiring cycle carries no byte, so byte_cnt_q is already final.
      if (in_drain && drain_expired) done_bytes <= byte_cnt_q;
    end
  end

endmodule

// File: tb/tb_jls_frame_ctrl.sv
// Self-checking bench for jls_frame_ctrl: a timestamp-based frame model
// checked every cycle, plus directed frames with literal expectations.
module tb_jls_frame_ctrl;

  localparam int SETUP_CYCLES = 16;
  localparam int DRAIN_IDLE   = 64;
  localparam int MIN_WIDTH    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [11:0] cfg_width = '0;
  logic [15:0] cfg_height = '0;
  logic        cfg_err;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = '0;
  logic        enc_rst;
  logic [11:0] enc_width;
  logic [15:0] enc_height;
  logic        enc_ivalid;
  logic [7:0]  enc_idata;
  logic        enc_ovalid = 1'b0;
  logic        done;
  logic [31:0] done_bytes;
  logic        busy;

  jls_frame_ctrl #(
    .MAXLEN_LEVEL(12),
    .MIN_WIDTH   (MIN_WIDTH),
    .SETUP_CYCLES(SETUP_CYCLES),
    .DRAIN_IDLE  (DRAIN_IDLE)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_width(cfg_width),
    .cfg_height(cfg_height), .cfg_err(cfg_err),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .enc_rst(enc_rst), .enc_width(enc_width), .enc_height(enc_height),
    .enc_ivalid(enc_ivalid), .enc_idata(enc_idata), .enc_ovalid(enc_ovalid),
    .done(done), .done_bytes(done_bytes), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Frame model: tracks event timestamps (accept, first/last pixel, last
  // output activity) and derives every output from them.
  bit         m_active, m_prev_acc;
  int         m_t_acc, m_total, m_taken, m_t_first, m_t_last, m_t_act, m_t_err, m_bytes;
  int         m_w, m_h;
  logic [7:0] m_prev_data;
  longint     m_db;

  always @(negedge clk) begin : model
    bit e_done, e_sready, e_rst, was_active, acc;
    if (rst) begin
      chk("rst_cfg_ready", cfg_ready, 1);
      chk("rst_enc_rst", enc_rst, 1);
      chk("rst_enc_ivalid", enc_ivalid, 0);
      chk("rst_enc_idata", enc_idata, 0);
      chk("rst_enc_width", enc_width, 0);
      chk("rst_enc_height", enc_height, 0);
      chk("rst_cfg_err", cfg_err, 0);
      chk("rst_done", done, 0);
      chk("rst_done_bytes", done_bytes, 0);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_busy", busy, 0);
      m_active = 0; m_prev_acc = 0; m_t_acc = -1000; m_total = 0; m_taken = 0;
      m_t_first = -1; m_t_last = -1; m_t_act = -1000; m_t_err = -10; m_bytes = 0;
      m_w = 0; m_h = 0; m_db = 0; m_prev_data = '0;
    end else begin
      e_done   = m_active && (m_t_last >= 0) && (cyc == m_t_act + DRAIN_IDLE + 1);
      if (e_done) m_db = m_bytes;
      e_sready = m_active && (cyc >= m_t_acc + SETUP_CYCLES + 1) && (m_taken < m_total);
      e_rst    = !(m_active && (m_t_first >= 0) && (cyc > m_t_first) &&
                   ((m_t_last < 0) || (cyc <= m_t_last + 1)));
      chk("cfg_ready", cfg_ready, !m_active);
      chk("busy", busy, m_active);
      chk("s_ready", s_ready, e_sready);
      chk("enc_ivalid", enc_ivalid, m_prev_acc);
      if (m_prev_acc) chk("enc_idata", enc_idata, m_prev_data);
      chk("enc_rst", enc_rst, e_rst);
      chk("done", done, e_done);
      chk("done_bytes", done_bytes, m_db);
      chk("cfg_err", cfg_err, cyc == m_t_err + 1);
      chk("enc_width", enc_width, m_w);
      chk("enc_height", enc_height, m_h);

      was_active = m_active;
      if (m_active && enc_ovalid) m_bytes++;
      acc = e_sready && s_valid;
      if (acc) begin
        m_taken++;
        if (m_taken == 1) m_t_first = cyc;
        if (m_taken == m_total) begin
          m_t_last = cyc;
          m_t_act  = cyc;
        end
      end
      m_prev_acc  = acc;
      m_prev_data = s_data;
      if (m_active && (m_t_last >= 0) && (cyc > m_t_last) && !e_done && enc_ovalid)
        m_t_act = cyc;
      if (e_done) begin
        m_active = 0;
      end else if (!was_active && cfg_valid) begin
        if ((int'(cfg_width) < MIN_WIDTH) || (cfg_height == 0)) begin
          m_t_err = cyc;
        end else begin
          m_active = 1; m_t_acc = cyc; m_w = cfg_width; m_h = cfg_height;
          m_total = m_w * m_h; m_taken = 0; m_t_first = -1; m_t_last = -1;
          m_t_act = -1000; m_bytes = 0;
        end
      end
    end
  end

  // Stimulus state.
  int mode = 0;      // 0: always valid, 1: valid on even cycles
  int ov_mode = 0;   // 0: none, 1: every 3rd cycle until last pixel, 2: schedule
  int ov_base = -1000;
  int n_iv = 0, last_iv = -1, last_ov = -1, done_c = -1, n_done = 0;
  int first_sr = -1, n_err = 0, busy_seen = 0;

  task automatic step();
    @(posedge clk);
    #1;
    case (mode)
      0:       s_valid = 1'b1;
      1:       s_valid = (cyc % 2 == 0);
      default: s_valid = 1'b0;
    endcase
    s_data = 8'(cyc * 13 + 5);
    case (ov_mode)
      1:       enc_ovalid = (cyc % 3 == 0) && (n_iv < 8);
      2:       enc_ovalid = ((cyc - ov_base) inside {2, 3, 4, 44, 45});
      default: enc_ovalid = 1'b0;
    endcase
    if (enc_ivalid) begin n_iv++; last_iv = cyc; end
    if (enc_ovalid) last_ov = cyc;
    if (done) begin n_done++; done_c = cyc; end
    if (cfg_err) n_err++;
    if (busy) busy_seen++;
    if (s_ready && first_sr < 0) first_sr = cyc;
  endtask

  task automatic start_cfg(input int w, input int h);
    cfg_valid  = 1'b1;
    cfg_width  = 12'(w);
    cfg_height = 16'(h);
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic run_until_done(input int budget, input string tag);
    int start = n_done;
    for (int k = 0; k < budget && n_done == start; k++) step();
    chk({tag, "_done_seen"}, n_done - start, 1);
  endtask

  task automatic run_until_iv(input int target, input int budget, input string tag);
    for (int k = 0; k < budget && n_iv < target; k++) step();
    chk({tag, "_iv_reached"}, n_iv >= target, 1);
  endtask

  initial begin
    int acc_c, nd;
    repeat (3) step();
    chk("lit_reset_cfg_ready", cfg_ready, 1);
    chk("lit_reset_enc_rst", enc_rst, 1);
    rst = 1'b0;
    step();

    // Frame 4x2, always-valid source.
    first_sr = -1; n_iv = 0;
    start_cfg(4, 2);
    acc_c = cyc - 1;
    run_until_done(300, "t1");
    chk("t1_setup_len", first_sr - acc_c, SETUP_CYCLES + 1);
    chk("t1_pixels", n_iv, 8);
    chk("t1_done_after_last_pixel", done_c - last_iv, 64);
    chk("t1_done_bytes", done_bytes, 0);

    // Same frame, toggling source, bytes during setup and stream.
    step();
    mode = 1; ov_mode = 1; n_iv = 0;
    start_cfg(4, 2);
    run_until_done(300, "t2");
    chk("t2_pixels", n_iv, 8);

    // Rejected descriptors.
    mode = 0; ov_mode = 0;
    step();
    n_err = 0; busy_seen = 0;
    start_cfg(3, 5);
    step(); step();
    start_cfg(4, 0);
    step(); step();
    chk("t3_err_pulses", n_err, 2);
    chk("t3_busy_cycles", busy_seen, 0);
    chk("t3_width_kept", enc_width, 4);
    chk("t3_height_kept", enc_height, 2);

    // Drain with scheduled output bytes.
    ov_mode = 2; ov_base = -1000; n_iv = 0; last_ov = -1;
    start_cfg(5, 1);
    run_until_iv(5, 100, "t4");
    ov_base = cyc;
    run_until_done(300, "t4");
    chk("t4_done_after_last_byte", done_c - last_ov, 65);
    chk("t4_done_bytes", done_bytes, 5);
    ov_mode = 0; ov_base = -1000;

    // Second descriptor held off during a frame.
    step();
    n_iv = 0;
    cfg_valid = 1'b1; cfg_width = 12'd4; cfg_height = 16'd3;
    step();
    cfg_width = 12'd6; cfg_height = 16'd2;
    run_until_done(300, "t5a");
    step();
    step();
    cfg_valid = 1'b0;
    run_until_done(300, "t5b");
    chk("t5_width", enc_width, 6);
    chk("t5_height", enc_height, 2);
    chk("t5_pixels", n_iv, 24);

    // Reset mid-stream, then a clean frame.
    step();
    n_iv = 0;
    start_cfg(4, 2);
    run_until_iv(3, 100, "t6");
    rst = 1'b1;
    #1;
    chk("t6_async_enc_rst", enc_rst, 1);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_ivalid", enc_ivalid, 0);
    step();
    rst = 1'b0;
    nd = n_done;
    repeat (100) step();
    chk("t6_no_done", n_done - nd, 0);
    n_iv = 0;
    start_cfg(4, 2);
    run_until_done(300, "t6");
    chk("t6_pixels", n_iv, 8);
    chk("t6_done_bytes", done_bytes, 0);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
